param_master_port: RTL and testbench

PARAM_MASTER_PORT -- requirements
Module: param_master_port

---
 rtl/param_master_port_pkg.sv | 31 +++
 rtl/param_master_port_if.sv | 42 ++++
 rtl/param_master_port_serdes.sv | 41 ++++
 rtl/param_master_port.sv | 163 ++++++++++++++++
 tb/tb_param_master_port.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/param_master_port_pkg.sv
// Shared types and constants for the parameter master port: FSM state
// encoding and the serial-bus mode values.
package mp_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_ADDR  = 3'd2;
  localparam logic [2:0] ST_WDATA = 3'd3;
  localparam logic [2:0] ST_RWAIT = 3'd4;
  localparam logic [2:0] ST_RDATA = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;

  typedef enum logic [2:0] {
    MP_IDLE  = ST_IDLE,
    MP_REQ   = ST_REQ,
    MP_ADDR  = ST_ADDR,
    MP_WDATA = ST_WDATA,
    MP_RWAIT = ST_RWAIT,
    MP_RDATA = ST_RDATA,
    MP_DONE  = ST_DONE
  } mp_state_t;

  localparam logic MP_MODE_WR = 1'b1;
  localparam logic MP_MODE_RD = 1'b0;

  // True while the port is driving serial bits onto the bus.
  function automatic logic mp_is_tx(input mp_state_t s);
    return (s == MP_ADDR) || (s == MP_WDATA);
  endfunction

endpackage

// File: rtl/param_master_port_if.sv
// Host request port plus serial parameter bus of the master port, with the
// master (port side) and slave (host/arbiter/serial slave side) views.
interface param_master_port_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  // Handshakes: a host request transfers on a rising edge with m_valid && m_ready;
  // a serial bit transfers on a rising edge with mp_valid && mp_ready && mp_bgnt;
  // a read bit transfers on a rising edge with mp_rvalid while the read is waiting.
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_we;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_rdata;
  logic              m_rvalid;
  logic              m_err;
  logic              mp_breq;
  logic              mp_bgnt;
  logic              mp_addr;
  logic              mp_wdata;
  logic              mp_mode;
  logic              mp_valid;
  logic              mp_ready;
  logic              mp_rdata;
  logic              mp_rvalid;

  modport master (
    input  m_addr, m_wdata, m_we, m_valid,
    output m_ready, m_rdata, m_rvalid, m_err,
    output mp_breq, mp_addr, mp_wdata, mp_mode, mp_valid,
    input  mp_bgnt, mp_ready, mp_rdata, mp_rvalid
  );

  modport slave (
    output m_addr, m_wdata, m_we, m_valid,
    input  m_ready, m_rdata, m_rvalid, m_err,
    input  mp_breq, mp_addr, mp_wdata, mp_mode, mp_valid,
    output mp_bgnt, mp_ready, mp_rdata, mp_rvalid
  );

endinterface

// File: rtl/param_master_port_serdes.sv
// LSB-first shift register with bit counter; shifts right, new bits enter at
// the MSB, so after W shifts the first bit received sits in bit 0.
module mp_serdes #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load_i,
  input  logic [W-1:0] load_data_i,
  input  logic         shift_i,
  input  logic         in_bit_i,
  output logic         bit_o,
  output logic [W-1:0] data_o,
  output logic         done_o
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  logic [W-1:0]  sh_q;
  logic [CW-1:0] cnt_q;
  logic          last;

  assign last   = (cnt_q == CW'(W - 1));
  assign bit_o  = sh_q[0];
  assign data_o = sh_q;
  assign done_o = shift_i && last;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      sh_q  <= load_data_i;
      cnt_q <= '0;
    end else if (shift_i) begin
      sh_q  <= (sh_q >> 1) | (W'(in_bit_i) << (W - 1));
      cnt_q <= last ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/param_master_port.sv
// Parameter master port: turns one host read/write into a serial LSB-first
// frame on an arbitrated bus. Optional watchdog abort via MP_TIMEOUT_EN.
module param_master_port
  import mp_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int TMO_CYC = 255
) (
  input  logic                 clk,
  input  logic                 rstn,
  param_master_port_if.master  bus,
  output mp_state_t            state_o
);

  mp_state_t         state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              we_q;
  logic              init_q;
  logic              accept;
  logic              xfer_load;
  logic              rd_done_now;
  logic              tmo_hit;

  logic              a_shift, a_bit, a_done;
  logic              w_shift, w_bit, w_done;
  logic              r_shift, r_done;
  logic [DATA_W-1:0] r_data;
  logic [ADDR_W-1:0] a_data_unused;
  logic [DATA_W-1:0] w_data_unused;
  logic              r_bit_unused;

  assign accept      = bus.m_valid && bus.m_ready;
  assign xfer_load   = (state_q == MP_REQ) && bus.mp_bgnt;
  assign a_shift     = (state_q == MP_ADDR) && bus.mp_bgnt && bus.mp_ready;
  assign w_shift     = (state_q == MP_WDATA) && bus.mp_bgnt && bus.mp_ready;
  assign r_shift     = ((state_q == MP_RWAIT) || (state_q == MP_RDATA)) &&
                       bus.mp_bgnt && bus.mp_rvalid;
  assign rd_done_now = (state_q == MP_DONE) && (we_q == MP_MODE_RD);

  // Every grant restarts the frame from address bit 0.
  mp_serdes #(.W(ADDR_W)) u_addr (
    .clk(clk), .rstn(rstn), .load_i(xfer_load), .load_data_i(addr_q),
    .shift_i(a_shift), .in_bit_i(1'b0),
    .bit_o(a_bit), .data_o(a_data_unused), .done_o(a_done)
  );

  mp_serdes #(.W(DATA_W)) u_wdata (
    .clk(clk), .rstn(rstn), .load_i(xfer_load), .load_data_i(wdata_q),
    .shift_i(w_shift), .in_bit_i(1'b0),
    .bit_o(w_bit), .data_o(w_data_unused), .done_o(w_done)
  );

  mp_serdes #(.W(DATA_W)) u_rdata (
    .clk(clk), .rstn(rstn), .load_i(xfer_load), .load_data_i('0),
    .shift_i(r_shift), .in_bit_i(bus.mp_rdata),
    .bit_o(r_bit_unused), .data_o(r_data), .done_o(r_done)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      MP_IDLE:  if (accept) state_d = MP_REQ;
      MP_REQ:   if (bus.mp_bgnt) state_d = MP_ADDR;
      MP_ADDR: begin
        if (!bus.mp_bgnt)  state_d = MP_REQ;
        else if (a_done)   state_d = (we_q == MP_MODE_WR) ? MP_WDATA : MP_RWAIT;
      end
      MP_WDATA: begin
        if (!bus.mp_bgnt)  state_d = MP_REQ;
        else if (w_done)   state_d = MP_DONE;
      end
      MP_RWAIT: begin
        if (!bus.mp_bgnt)        state_d = MP_REQ;
        else if (bus.mp_rvalid)  state_d = r_done ? MP_DONE : MP_RDATA;
      end
      MP_RDATA: begin
        if (!bus.mp_bgnt)  state_d = MP_REQ;
        else if (r_done)   state_d = MP_DONE;
      end
      MP_DONE:  state_d = MP_IDLE;
      default:  state_d = MP_IDLE;
    endcase
    if (tmo_hit) state_d = MP_IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= MP_IDLE;
      init_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= MP_MODE_RD;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      init_q  <= 1'b1;
      if (accept) begin
        addr_q  <= bus.m_addr;
        wdata_q <= bus.m_wdata;
        we_q    <= bus.m_we;
      end
      if (rd_done_now) rdata_q <= r_data;
    end
  end

`ifdef MP_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYC + 1);

  logic [TW-1:0] tmo_q, tmo_d;
  logic          tmo_cnt_en;
  logic          err_q;

  // Only waiting cycles count; a cycle that moves a bit does not.
  always_comb begin
    tmo_cnt_en = 1'b0;
    case (state_q)
      MP_REQ, MP_RWAIT:  tmo_cnt_en = 1'b1;
      MP_ADDR, MP_WDATA: tmo_cnt_en = !bus.mp_ready;
      MP_RDATA:          tmo_cnt_en = !bus.mp_rvalid;
      default:           tmo_cnt_en = 1'b0;
    endcase
  end

  assign tmo_hit = tmo_cnt_en && (tmo_q == TW'(TMO_CYC - 1));

  always_comb begin
    tmo_d = tmo_q;
    if (state_d != state_q) tmo_d = '0;
    else if (tmo_cnt_en)    tmo_d = tmo_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= tmo_hit;
    end
  end

  assign bus.m_err = err_q;
`else
  localparam int TMO_CYC_UNUSED = TMO_CYC;
  assign tmo_hit   = 1'b0;
  assign bus.m_err = 1'b0;
`endif

  assign state_o      = state_q;
  assign bus.m_ready  = init_q && (state_q == MP_IDLE);
  assign bus.m_rvalid = rd_done_now;
  // The freshly assembled word is shown during DONE, then held in rdata_q.
  assign bus.m_rdata  = rd_done_now ? r_data : rdata_q;
  assign bus.mp_breq  = (state_q != MP_IDLE);
  assign bus.mp_valid = mp_is_tx(state_q);
  assign bus.mp_mode  = mp_is_tx(state_q) ? we_q : MP_MODE_RD;
  assign bus.mp_addr  = (state_q == MP_ADDR) && a_bit;
  assign bus.mp_wdata = (state_q == MP_WDATA) && w_bit;

endmodule

// File: tb/tb_param_master_port.sv
// Directed bench for param_master_port: reset, write/read frames, stall,
// grant loss, ignored requests, reset mid-read and (MP_TIMEOUT_EN) timeout.
module tb_param_master_port;
  import mp_pkg::*;

  localparam int AW = 16;
  localparam int DW = 8;

  logic      clk  = 1'b0;
  logic      rstn = 1'b0;
  mp_state_t dut_state;

  int checks  = 0;
  int errors  = 0;
  int acc_n   = 0;
  int rv_cnt  = 0;
  int err_cnt = 0;
  int lat     = 0;
  logic [DW-1:0] rv_data = '0;
  logic [2:0]    exp_q[$];

  param_master_port_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  param_master_port #(.ADDR_W(AW), .DATA_W(DW), .TMO_CYC(10)) dut (
    .clk(clk), .rstn(rstn), .bus(bus), .state_o(dut_state)
  );

  // ---- clock / watchdog ----
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---- checking ----
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void push_frame(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                     input logic we, input int nd);
    for (int i = 0; i < AW; i++) exp_q.push_back({1'b1, we, a[i]});
    for (int i = 0; i < nd; i++) exp_q.push_back({1'b1, we, d[i]});
  endfunction

  // ---- scoreboard monitor: serial bits, strobes, idle line levels ----
  always @(negedge clk) begin : mon
    logic [2:0] e, g;
    if (rstn) begin
      if (bus.mp_valid && bus.mp_bgnt) begin
        e = (exp_q.size() != 0) ? exp_q[0] : 3'b000;
        g = {1'b1, bus.mp_mode, bus.mp_addr | bus.mp_wdata};
        if (bus.mp_ready) begin
          chk("ser_bit", g, e);
          if (exp_q.size() != 0) exp_q.delete(0);
          acc_n++;
        end else begin
          chk("ser_hold", g, e);
        end
      end
      if (!bus.mp_valid) chk("idle_lines", {bus.mp_addr, bus.mp_wdata, bus.mp_mode}, 3'b000);
      if (bus.m_rvalid) begin
        rv_cnt++;
        rv_data = bus.m_rdata;
      end
      if (bus.m_err) err_cnt++;
    end
  end

  // ---- driver tasks ----
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic we,
                        output int l);
    int n;
    n = 0;
    while (!bus.m_ready && n < 100) begin tick(); n++; end
    bus.m_addr  = a;
    bus.m_wdata = d;
    bus.m_we    = we;
    bus.m_valid = 1'b1;
    tick();
    bus.m_valid = 1'b0;
    l = 0;
    while (!bus.m_ready && l < 200) begin tick(); l++; end
  endtask

  task automatic wait_acc(input int target);
    int n;
    n = 0;
    while (acc_n < target && n < 200) begin tick(); n++; end
    chk("acc_wait", acc_n, target);
  endtask

  // ---- stimulus ----
  initial begin
    logic [DW-1:0] rd;
    int rv0;
    bus.m_addr = '0; bus.m_wdata = '0; bus.m_we = 1'b0; bus.m_valid = 1'b0;
    bus.mp_bgnt = 1'b1; bus.mp_ready = 1'b1; bus.mp_rdata = 1'b0; bus.mp_rvalid = 1'b0;

    // reset state
    #2;
    chk("rst_outs", {bus.m_ready, bus.m_rvalid, bus.m_err, bus.mp_breq, bus.mp_valid,
                     bus.mp_mode, bus.mp_addr, bus.mp_wdata}, 8'h00);
    chk("rst_rdata", bus.m_rdata, 8'h00);
    chk("rst_state", dut_state, MP_IDLE);
    #10 rstn = 1'b1;
    #1 chk("rdy_before_edge", bus.m_ready, 1'b0);
    tick();
    chk("rdy_after_edge", bus.m_ready, 1'b1);

    // plain write, with a second request offered while busy (must be ignored)
    acc_n = 0;
    push_frame(16'h1234, 8'h75, 1'b1, DW);
    fork
      do_req(16'h1234, 8'h75, 1'b1, lat);
      begin
        tick(); tick();
        bus.m_valid = 1'b1; bus.m_addr = 16'hFFFF; bus.m_we = 1'b0;
        repeat (5) tick();
        bus.m_valid = 1'b0;
      end
    join
    chk("wr_lat", lat, 26);
    repeat (4) tick();
    chk("ignored_req_breq", bus.mp_breq, 1'b0);
    chk("wr_left", exp_q.size(), 0);
    chk("wr_no_rvalid", rv_cnt, 0);

    // read 00A5, slave returns 3C after two idle RWAIT cycles
    acc_n = 0;
    rd = 8'h3C;
    push_frame(16'h00A5, 8'h00, 1'b0, 0);
    fork
      do_req(16'h00A5, 8'h00, 1'b0, lat);
      begin
        wait_acc(AW);
        tick(); tick();
        for (int i = 0; i < DW; i++) begin
          bus.mp_rvalid = 1'b1; bus.mp_rdata = rd[i]; tick();
        end
        bus.mp_rvalid = 1'b0; bus.mp_rdata = 1'b0;
      end
    join
    chk("rd_lat", lat, 28);
    chk("rd_pulses", rv_cnt, 1);
    chk("rd_pulse_data", rv_data, 8'h3C);
    chk("rd_hold", bus.m_rdata, 8'h3C);
    chk("rd_left", exp_q.size(), 0);

    // write with mp_ready low for 3 cycles at address bit 5
    acc_n = 0;
    push_frame(16'h1234, 8'h75, 1'b1, DW);
    fork
      do_req(16'h1234, 8'h75, 1'b1, lat);
      begin
        wait_acc(5);
        bus.mp_ready = 1'b0;
        repeat (3) tick();
        bus.mp_ready = 1'b1;
      end
    join
    chk("stall_lat", lat, 29);
    chk("stall_left", exp_q.size(), 0);
    chk("rdata_kept_over_wr", bus.m_rdata, 8'h3C);

    // grant lost at write data bit 2, regranted two cycles later
    acc_n = 0;
    push_frame(16'hABCD, 8'h5A, 1'b1, 2);
    push_frame(16'hABCD, 8'h5A, 1'b1, DW);
    fork
      do_req(16'hABCD, 8'h5A, 1'b1, lat);
      begin
        wait_acc(AW + 2);
        bus.mp_bgnt = 1'b0;
        tick();
        chk("regrant_breq", bus.mp_breq, 1'b1);
        chk("regrant_valid", bus.mp_valid, 1'b0);
        tick();
        bus.mp_bgnt = 1'b1;
      end
    join
    chk("regrant_lat", lat, 47);
    chk("regrant_left", exp_q.size(), 0);
    chk("regrant_no_err", err_cnt, 0);
    chk("regrant_no_rvalid", rv_cnt, 1);

`ifdef MP_TIMEOUT_EN
    // read that never gets data: abort after 10 RWAIT cycles
    acc_n = 0;
    push_frame(16'h0F0F, 8'h00, 1'b0, 0);
    do_req(16'h0F0F, 8'h00, 1'b0, lat);
    chk("tmo_lat", lat, 27);
    chk("tmo_err_now", bus.m_err, 1'b1);
    chk("tmo_breq", bus.mp_breq, 1'b0);
    tick();
    chk("tmo_err_pulses", err_cnt, 1);
    chk("tmo_left", exp_q.size(), 0);
`endif

    // reset in the middle of a read
    acc_n = 0;
    rv0 = rv_cnt;
    push_frame(16'h00A5, 8'h00, 1'b0, 0);
    bus.m_addr = 16'h00A5; bus.m_we = 1'b0; bus.m_valid = 1'b1;
    tick();
    bus.m_valid = 1'b0;
    wait_acc(AW);
    for (int i = 0; i < 3; i++) begin
      bus.mp_rvalid = 1'b1; bus.mp_rdata = rd[i]; tick();
    end
    #2 rstn = 1'b0;
    #1;
    chk("midrst_outs", {bus.m_ready, bus.m_rvalid, bus.m_err, bus.mp_breq, bus.mp_valid,
                        bus.mp_mode, bus.mp_addr, bus.mp_wdata}, 8'h00);
    chk("midrst_rdata", bus.m_rdata, 8'h00);
    chk("midrst_state", dut_state, MP_IDLE);
    bus.mp_rvalid = 1'b0; bus.mp_rdata = 1'b0;
    #2 rstn = 1'b1;
    #1 chk("midrst_rdy_before_edge", bus.m_ready, 1'b0);
    tick();
    chk("midrst_rdy_after_edge", bus.m_ready, 1'b1);
    repeat (3) tick();
    chk("midrst_no_rvalid", rv_cnt, rv0);
    chk("midrst_left", exp_q.size(), 0);

`ifndef MP_TIMEOUT_EN
    chk("no_err_total", err_cnt, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
